csi_packet_parser: RTL and testbench
====================================

# csi_packet_parser

Parses merged two-lane CSI-2 byte streams into payload words for the RAW10 decoder directly downstream. Consumes 16-bit words from the lane merger, decodes packet headers, and tracks frame start/end short packets. Strips headers and CRC, and forwards only long-packet payload of the configured data type as `dout` / `frame_valid`. It also drives the `frame_active` level that the decoder uses to bound a frame.

## Interface
- `DATA_TYPE`, default 8'h2B: long-packet data type forwarded (RAW10); other long packets are consumed and dropped.
- `VC`, default 2'd0: virtual channel accepted; packets on other VCs are consumed and dropped.
- `clk`  in  1: sole clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `din`  in  16: merged word; lane 0 byte in [7:0] is earlier in stream order, lane 1 byte in [15:8].
- `din_valid`  in  1: `din` carries a word this cycle.
- `sync`  in  1: one-cycle pulse with the first valid word after HS start-of-transmission.
- `dout`  out  16: payload word, byte order as `din`.
- `frame_active`  out  1: level, high between accepted FS and FE.
- `frame_valid`  out  1: `dout` holds a forwarded payload word this cycle.
- `pkt_err`  out  1: one-cycle pulse on any packet error.

## Operation
- Header = 2 words: H0 = {WC[7:0], DI}; H1 = {ECC, WC[15:8]}. DI[7:6] = VC, DI[5:0] = DT.
- FSM states: IDLE, HDR1, PAYLOAD, CRC, DRAIN.
  - IDLE: wait for `sync` & `din_valid`; latch that word as H0 and go to HDR1. Valid words without `sync` are ignored.
  - HDR1 on a valid word: evaluate the header.
    - Short packet (DT < 0x10): DT 0x00 (FS) sets `frame_active`; DT 0x01 (FE) clears it. Other short packets are ignored. Go to IDLE.
    - Long packet with WC = 0: go to CRC.
    - Long packet with odd WC: `pkt_err`, go to IDLE.
    - Otherwise: load word counter = WC/2 and go to PAYLOAD. Set forward flag = (DT == `DATA_TYPE`) & (VC == `VC`) & `frame_active`.
  - PAYLOAD: each valid word decrements the counter and, if forward flag is set, is presented on `dout` with `frame_valid`. On the last word, go to CRC.
  - CRC: one valid word consumed, not checked, not forwarded; go to IDLE.
  - DRAIN: not entered in normal flow; reserved for the ECC error path (see Configuration).
- `din_valid` low in any state: state, counter and outputs hold; `frame_valid` = 0.
- `sync` in any non-IDLE state: pulse `pkt_err`, abandon the current packet, and treat the word as a new H0 (go to HDR1). `frame_active` is unchanged.
- FS while already active: stays high, no error. FE while inactive: no effect.
- Counter width is 15 bits and WC/2 ≤ 32767, so the counter never wraps.

## Timing
- All outputs are registered.
- `dout` / `frame_valid` appear 1 cycle after the payload word's `din_valid` cycle.
- `frame_active` changes 1 cycle after the H1 word of FS/FE. The first forwarded `frame_valid` of a line can therefore never precede `frame_active`.
- `pkt_err` asserts 1 cycle after the offending word.
- Reset values: `dout` = 0, `frame_valid` = 0, `frame_active` = 0, `pkt_err` = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-packet clears everything immediately. Words after deassertion are ignored until the next `sync`.
- Throughput is one word per cycle; there is no backpressure.

## Configuration
- `CSIRX_ECC_CHECK_EN` defined:
  - In HDR1, compute the CSI-2 6-bit Hamming parity over {WC[15:0], DI} and compare it with ECC[5:0]; ECC[7:6] must be 0.
  - On mismatch: pulse `pkt_err`, take no FS/FE action, and go to DRAIN.
  - DRAIN discards all words until the next `sync`, which starts a new H0.
  - The header is not corrected.
- Undefined: the ECC byte is ignored, DRAIN is unreachable, and the error logic is compiled out.

## Test plan
- FS header H0 = 0x0100, H1 = {ECC, 0x00} with `sync` on H0 -> `frame_active` rises 1 cycle after H1; no `frame_valid`.
- After FS, long packet with DI = 0x2B, WC = 10: 5 payload words 0x1111..0x5555 then CRC -> `frame_valid` high for exactly 5 cycles with `dout` = 0x1111..0x5555 in order; CRC word not forwarded.
- Same packet with DI = 0x2A -> zero `frame_valid` cycles. Same packet with `din_valid` low on alternate cycles -> 5 words forwarded, each 1 cycle after its valid.
- FE header (DI = 0x01) -> `frame_active` falls 1 cycle after H1. A RAW10 line sent afterwards is not forwarded.
- WC = 9 -> `pkt_err` pulse, no forwarding. `sync` reasserted on payload word 3 of 5 -> `pkt_err`, that word parsed as a new H0.
- With `CSIRX_ECC_CHECK_EN`: FS with ECC bit 0 flipped -> `pkt_err` pulse, `frame_active` stays 0, words ignored until next `sync`. Reset asserted mid-payload -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/csi_packet_parser_if.sv
// ---------------------------------------------------------------------------
// csi_packet_parser_if
//   Word stream between the lane merger, the packet parser and the RAW10
//   decoder.
//   master : drives din/din_valid/sync, observes the parser outputs.
//   slave  : the parser; consumes din/din_valid/sync and drives
//            dout/frame_active/frame_valid/pkt_err.
//   din/dout   : 16-bit word, lane 0 byte in [7:0] (earlier), lane 1 in [15:8]
//   din_valid  : din carries a word this cycle
//   sync       : pulse with the first valid word after HS start-of-transmission
//   frame_active : high between accepted FS and FE
//   frame_valid  : dout holds a forwarded payload word this cycle
//   pkt_err      : one-cycle pulse on any packet error
// ---------------------------------------------------------------------------
interface csi_packet_parser_if;
    logic [15:0] din;
    logic        din_valid;
    logic        sync;
    logic [15:0] dout;
    logic        frame_active;
    logic        frame_valid;
    logic        pkt_err;

    modport master (
        output din, din_valid, sync,
        input  dout, frame_active, frame_valid, pkt_err
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, frame_active, frame_valid, pkt_err
    );
endinterface

// File: rtl/csi_packet_parser.sv
// ---------------------------------------------------------------------------
// csi_packet_parser
//   Parses the merged two-lane CSI-2 word stream. Decodes the two-word packet
//   header, tracks frame start/end short packets, strips header and CRC and
//   forwards only long-packet payload of DATA_TYPE on virtual channel VC while
//   a frame is active.
//
//   Parameters : DATA_TYPE (forwarded long-packet data type, default RAW10)
//                VC        (accepted virtual channel)
//   Ports      : clk   - sole clock, rising edge
//                reset - asynchronous, active-high
//                bus   - csi_packet_parser_if.slave (din/din_valid/sync in,
//                        dout/frame_active/frame_valid/pkt_err out)
//
//   Optional feature macro: CSIRX_ECC_CHECK_EN
//     Defined   : header ECC is checked; a mismatch pulses pkt_err and the
//                 parser discards words (DRAIN) until the next sync.
//     Undefined : the ECC byte is ignored and DRAIN is unreachable.
// ---------------------------------------------------------------------------
module csi_packet_parser #(
    parameter logic [7:0] DATA_TYPE = 8'h2B,
    parameter logic [1:0] VC        = 2'd0
) (
    input logic               clk,
    input logic               reset,
    csi_packet_parser_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] h0_r, h0_s;
    logic [14:0] cnt_r, cnt_s;
    logic        fwd_r, fwd_s;
    logic [15:0] dout_r, dout_s;
    logic        frame_valid_r, frame_valid_s;
    logic        frame_active_r, frame_active_s;
    logic        pkt_err_r, pkt_err_s;

    // Header fields: H0 is held in h0_r, H1 is the word currently on din.
    logic [5:0]  hdr_dt_s;
    logic [1:0]  hdr_vc_s;
    logic [15:0] hdr_wc_s;

    assign hdr_dt_s = h0_r[5:0];
    assign hdr_vc_s = h0_r[7:6];
    assign hdr_wc_s = {bus.din[7:0], h0_r[15:8]};

`ifdef CSIRX_ECC_CHECK_EN
    // CSI-2 6-bit Hamming parity over the 24 header bits {WC, DI}.
    function automatic logic [5:0] csi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^ d[11] ^
               d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^ d[12] ^
               d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^ d[12] ^
               d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^ d[14] ^
               d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^ d[17] ^
               d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
               d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return p;
    endfunction

    logic [7:0] hdr_ecc_s;
    logic       ecc_bad_s;

    assign hdr_ecc_s = bus.din[15:8];
    // The header is only judged, never corrected; reserved ECC bits must be 0.
    assign ecc_bad_s = (hdr_ecc_s[7:6] != 2'b00) ||
                       (hdr_ecc_s[5:0] != csi_ecc({hdr_wc_s, h0_r[7:0]}));
`endif

    // Next-state and next-output decode of the packet FSM.
    always_comb begin
        state_s        = state_r;
        h0_s           = h0_r;
        cnt_s          = cnt_r;
        fwd_s          = fwd_r;
        dout_s         = dout_r;
        frame_valid_s  = 1'b0;
        frame_active_s = frame_active_r;
        pkt_err_s      = 1'b0;

        if (bus.din_valid) begin
            // A sync inside a packet abandons it; DRAIN is already an error
            // recovery state, so leaving it via sync is the expected exit.
            if (bus.sync && (state_r != ST_IDLE) && (state_r != ST_DRAIN)) begin
                pkt_err_s = 1'b1;
                h0_s      = bus.din;
                state_s   = ST_HDR1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DRAIN: begin
                        if (bus.sync) begin
                            h0_s    = bus.din;
                            state_s = ST_HDR1;
                        end else begin
                            state_s = state_r;
                        end
                    end
                    ST_HDR1: begin
`ifdef CSIRX_ECC_CHECK_EN
                        if (ecc_bad_s) begin
                            pkt_err_s = 1'b1;
                            state_s   = ST_DRAIN;
                        end else
`endif
                        begin
                            if (hdr_dt_s < 6'h10) begin
                                // Short packet: only FS/FE touch frame_active.
                                if (hdr_dt_s == 6'h00) begin
                                    frame_active_s = 1'b1;
                                end else if (hdr_dt_s == 6'h01) begin
                                    frame_active_s = 1'b0;
                                end else begin
                                    frame_active_s = frame_active_r;
                                end
                                state_s = ST_IDLE;
                            end else if (hdr_wc_s == 16'd0) begin
                                state_s = ST_CRC;
                            end else if (hdr_wc_s[0]) begin
                                pkt_err_s = 1'b1;
                                state_s   = ST_IDLE;
                            end else begin
                                cnt_s   = hdr_wc_s[15:1];
                                fwd_s   = ({2'b00, hdr_dt_s} == DATA_TYPE) &&
                                          (hdr_vc_s == VC) && frame_active_r;
                                state_s = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        cnt_s = cnt_r - 15'd1;
                        if (fwd_r) begin
                            dout_s        = bus.din;
                            frame_valid_s = 1'b1;
                        end else begin
                            dout_s = dout_r;
                        end
                        if (cnt_r == 15'd1) begin
                            state_s = ST_CRC;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end
                    ST_CRC: begin
                        state_s = ST_IDLE;
                    end
                    default: begin
                        state_s = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            h0_r           <= 16'd0;
            cnt_r          <= 15'd0;
            fwd_r          <= 1'b0;
            dout_r         <= 16'd0;
            frame_valid_r  <= 1'b0;
            frame_active_r <= 1'b0;
            pkt_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            h0_r           <= h0_s;
            cnt_r          <= cnt_s;
            fwd_r          <= fwd_s;
            dout_r         <= dout_s;
            frame_valid_r  <= frame_valid_s;
            frame_active_r <= frame_active_s;
            pkt_err_r      <= pkt_err_s;
        end
    end

    assign bus.dout         = dout_r;
    assign bus.frame_valid  = frame_valid_r;
    assign bus.frame_active = frame_active_r;
    assign bus.pkt_err      = pkt_err_r;

endmodule

// File: tb/tb_csi_packet_parser.sv
// ---------------------------------------------------------------------------
// tb_csi_packet_parser
//   Directed and randomized packet streams against a packet-level reference
//   model: each packet is judged from its header (type, VC, WC parity, frame
//   state) to decide which payload words must appear on dout, how many
//   pkt_err pulses are due and what frame_active must be afterwards.
// ---------------------------------------------------------------------------
module tb_csi_packet_parser;

    localparam logic [7:0] DT_RAW10 = 8'h2B;
    localparam logic [1:0] VC_ACC   = 2'd0;

    logic clk = 1'b0;
    logic reset;

    csi_packet_parser_if bus ();

    csi_packet_parser #(.DATA_TYPE(DT_RAW10), .VC(VC_ACC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_pass   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          exp_err  = 0;
    int          err_seen = 0;
    bit          model_fa = 1'b0;
    logic        last_v   = 1'b0;
    logic [15:0] last_d   = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference header ECC: parity bit i covers the header bits selected by mask i.
    function automatic logic [7:0] ref_ecc(input logic [23:0] d);
        logic [23:0] m [0:5];
        logic [7:0]  r;
        m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
        m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
        r = 8'h00;
        for (int i = 0; i < 6; i++) r[i] = ^(d & m[i]);
        return r;
    endfunction

    // Input-side record for the one-cycle latency check.
    always @(posedge clk) begin
        last_v <= bus.din_valid;
        last_d <= bus.din;
    end

    // Output monitor: every forwarded word must be the next expected one.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_valid) begin
                chk("fwd_latency", 32'(last_v), 32'd1);
                chk("fwd_same_word", 32'(bus.dout), 32'(last_d));
                chk("fwd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("fwd_data", 32'(bus.dout), 32'(exp_q.pop_front()));
            end
            if (bus.pkt_err) err_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic [15:0] w, input bit s, input bit v);
        @(negedge clk);
        bus.din       = w;
        bus.sync      = s;
        bus.din_valid = v;
    endtask

    // gap 0: back-to-back, 1: idle after every word, 2: random idles.
    task automatic put(input logic [15:0] w, input bit s, input int gap);
        drive(w, s, 1'b1);
        if (gap == 1) drive(16'($urandom), 1'b0, 1'b0);
        else if (gap == 2 && $urandom_range(0, 2) == 0) drive(16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic checkpoint(input string tag);
        drive(16'($urandom), 1'b0, 1'b0);
        #1;
        chk($sformatf("%s_frame_active", tag), 32'(bus.frame_active), 32'(model_fa));
        drive(16'($urandom), 1'b0, 1'b0);
        #1;
        chk($sformatf("%s_words_missing", tag), 32'(exp_q.size()), 32'd0);
        chk($sformatf("%s_pkt_err_count", tag), 32'(err_seen), 32'(exp_err));
        exp_q.delete();
        err_seen = exp_err;
    endtask

    task automatic send_packet(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                               input int gap, input bit seq);
        logic [15:0] h0, h1, w;
        bit          fwd;
        int          nw;
        h0 = {wc[7:0], vc, dt};
        h1 = {ref_ecc({wc, vc, dt}), wc[15:8]};
        if (dt < 6'h10) begin
            if (dt == 6'h00) model_fa = 1'b1;
            else if (dt == 6'h01) model_fa = 1'b0;
            put(h0, 1'b1, gap);
            put(h1, 1'b0, gap);
        end else begin
            fwd = (wc != 16'd0) && !wc[0] && ({2'b00, dt} == DT_RAW10) && (vc == VC_ACC) && model_fa;
            if (wc[0]) exp_err++;
            put(h0, 1'b1, gap);
            put(h1, 1'b0, gap);
            nw = (int'(wc) + 1) / 2;
            for (int i = 0; i < nw; i++) begin
                w = seq ? 16'((i + 1) * 32'h1111) : 16'($urandom);
                if (fwd) exp_q.push_back(w);
                put(w, 1'b0, gap);
            end
            put(16'($urandom), 1'b0, gap);
        end
    endtask

    initial begin
        logic [15:0] h1_bad;
        reset         = 1'b1;
        bus.din       = 16'd0;
        bus.sync      = 1'b0;
        bus.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_dout", 32'(bus.dout), 32'd0);
        chk("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("reset_frame_active", 32'(bus.frame_active), 32'd0);
        chk("reset_pkt_err", 32'(bus.pkt_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Frame start, then a RAW10 line of 0x1111..0x5555.
        send_packet(6'h00, 2'd0, 16'h0001, 0, 1'b0);
        checkpoint("fs");
        send_packet(6'h2B, 2'd0, 16'd10, 0, 1'b1);
        checkpoint("raw10_line");
        send_packet(6'h2A, 2'd0, 16'd10, 0, 1'b1);
        checkpoint("other_dt");
        send_packet(6'h2B, 2'd1, 16'd10, 0, 1'b1);
        checkpoint("other_vc");
        send_packet(6'h2B, 2'd0, 16'd10, 1, 1'b1);
        checkpoint("alt_valid");

        // sync on payload word 3 of 5: words 1-2 forwarded, word 3 becomes an FS H0.
        put(16'h0A2B, 1'b1, 0);
        put({ref_ecc({16'd10, 8'h2B}), 8'h00}, 1'b0, 0);
        exp_q.push_back(16'hA001);
        exp_q.push_back(16'hA002);
        put(16'hA001, 1'b0, 0);
        put(16'hA002, 1'b0, 0);
        put(16'h0000, 1'b1, 0);
        exp_err++;
        put({ref_ecc(24'h000000), 8'h00}, 1'b0, 0);
        put(16'hA004, 1'b0, 0);
        put(16'h0A2B, 1'b0, 0);
        put(16'hBEEF, 1'b0, 0);
        checkpoint("sync_mid_payload");

        // Odd word count while a frame is active.
        send_packet(6'h2B, 2'd0, 16'd9, 0, 1'b1);
        checkpoint("odd_wc");
        send_packet(6'h2B, 2'd0, 16'd0, 0, 1'b1);
        checkpoint("zero_wc");

        // Frame end, then a line that must be dropped; repeated FE is harmless.
        send_packet(6'h01, 2'd0, 16'h0001, 0, 1'b0);
        checkpoint("fe");
        send_packet(6'h2B, 2'd0, 16'd10, 0, 1'b1);
        checkpoint("line_after_fe");
        send_packet(6'h01, 2'd0, 16'h0002, 0, 1'b0);
        checkpoint("fe_inactive");
        send_packet(6'h00, 2'd0, 16'h0003, 0, 1'b0);
        send_packet(6'h00, 2'd0, 16'h0004, 0, 1'b0);
        checkpoint("fs_twice");

        for (int k = 0; k < 60; k++) begin
            int          sel;
            logic [5:0]  dt;
            logic [1:0]  vc;
            sel = $urandom_range(0, 9);
            dt  = (sel == 0) ? 6'h00 : (sel == 1) ? 6'h01 : (sel == 2) ? 6'h08 :
                  (sel == 3) ? 6'h2A : 6'h2B;
            vc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if ($urandom_range(0, 3) == 0) put(16'($urandom), 1'b0, 0);
            send_packet(dt, vc, 16'($urandom_range(0, 14)), $urandom_range(0, 2), 1'b0);
            checkpoint("random");
        end

        // Reset in the middle of a forwarded line.
        send_packet(6'h00, 2'd0, 16'h0005, 0, 1'b0);
        put(16'h0A2B, 1'b1, 0);
        put({ref_ecc({16'd10, 8'h2B}), 8'h00}, 1'b0, 0);
        exp_q.push_back(16'hC001);
        exp_q.push_back(16'hC002);
        put(16'hC001, 1'b0, 0);
        put(16'hC002, 1'b0, 0);
        drive(16'hC003, 1'b0, 1'b0);
        #1;
        chk("pre_reset_frame_valid", 32'(bus.frame_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_dout", 32'(bus.dout), 32'd0);
        chk("mid_reset_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("mid_reset_frame_active", 32'(bus.frame_active), 32'd0);
        chk("mid_reset_pkt_err", 32'(bus.pkt_err), 32'd0);
        model_fa = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        put(16'hC003, 1'b0, 0);
        put(16'h0100, 1'b0, 0);
        put(16'h0000, 1'b0, 0);
        put(16'hC005, 1'b0, 0);
        checkpoint("after_reset");

`ifdef CSIRX_ECC_CHECK_EN
        // FS whose ECC has bit 0 flipped: error, no frame start, drain to next sync.
        h1_bad = {ref_ecc({16'h0001, 8'h00}) ^ 8'h01, 8'h00};
        put(16'h0100, 1'b1, 0);
        put(h1_bad, 1'b0, 0);
        exp_err++;
        put(16'h0100, 1'b0, 0);
        put({ref_ecc({16'h0001, 8'h00}), 8'h00}, 1'b0, 0);
        put(16'h0A2B, 1'b0, 0);
        put({ref_ecc({16'd10, 8'h2B}), 8'h00}, 1'b0, 0);
        checkpoint("ecc_bad_fs");
        send_packet(6'h00, 2'd0, 16'h0001, 0, 1'b0);
        checkpoint("ecc_good_fs");
        send_packet(6'h2B, 2'd0, 16'd10, 0, 1'b1);
        checkpoint("ecc_line");
`else
        h1_bad = {8'hFF, 8'h00};
        send_packet(6'h00, 2'd0, 16'h0001, 0, 1'b0);
        put(16'h0A2B, 1'b1, 0);
        put(h1_bad | 16'd0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'(32'hD000 + i));
            put(16'(32'hD000 + i), 1'b0, 0);
        end
        put(16'hFFFF, 1'b0, 0);
        checkpoint("ecc_ignored");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
